// File: rtl/fft_adapter_pkg.sv
// Shared widths, error-bit indices and framing states for the FFT Avalon-ST adapters.
package fft_adapter_pkg;

  localparam int unsigned ERR_SAT   = 0;
  localparam int unsigned ERR_FRAME = 1;

  typedef enum logic {
    StIdle,
    StInPkt
  } frame_state_e;

  // Padded component width: guard MSBs + payload + fraction LSBs.
  function automatic int unsigned comp_width(input int unsigned sym_w, input int unsigned left_pad,
                                             input int unsigned right_pad);
    return left_pad + sym_w + right_pad;
  endfunction

  function automatic int unsigned out_data_width(input int unsigned sym_w);
    return 2 * sym_w;
  endfunction

endpackage

// File: rtl/fft_out_scaler.sv
// Narrows one padded two's-complement component: drop fraction LSBs, clamp guard MSBs.
// Rounding (half-up) is enabled by defining FFT_OUT_ADAPTER_ROUND_EN; otherwise floor.
module fft_out_scaler import fft_adapter_pkg::*; #(
  parameter int unsigned OutW     = 16,
  parameter int unsigned LeftPad  = 4,
  parameter int unsigned RightPad = 2
) (
  input  logic [comp_width(OutW, LeftPad, RightPad)-1:0] comp_i,
  output logic [OutW-1:0]                                value_o,
  output logic                                           sat_o
);

  localparam int unsigned CW = comp_width(OutW, LeftPad, RightPad);
  localparam int unsigned SW = CW + 1 - RightPad;

  logic [CW:0]      ext;
  logic [CW:0]      sum;
  logic [SW-1:0]    shifted;
  logic [SW-OutW:0] top;
  logic             fits;

  // One extra bit so the rounding add can never wrap.
  assign ext = {comp_i[CW-1], comp_i};

`ifdef FFT_OUT_ADAPTER_ROUND_EN
  if (RightPad > 0) begin : g_round
    localparam logic [CW:0] One = 1;
    assign sum = ext + (One << (RightPad - 1));
  end else begin : g_no_round
    assign sum = ext;
  end
`else
  assign sum = ext;
`endif

  if (RightPad > 0) begin : g_frac
    logic unused_frac;
    assign unused_frac = ^sum[RightPad-1:0];
  end

  assign shifted = sum[CW:RightPad];
  assign top     = shifted[SW-1:OutW-1];
  assign fits    = (&top) | ~(|top);

  always_comb begin
    value_o = shifted[OutW-1:0];
    sat_o   = 1'b0;
    if (!fits) begin
      sat_o   = 1'b1;
      value_o = shifted[SW-1] ? {1'b1, {(OutW-1){1'b0}}} : {1'b0, {(OutW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fft_output_adapter.sv
// FFT core output adapter: per-component narrowing, 2-entry skid buffer, packet framing check.
// Optional half-up rounding via FFT_OUT_ADAPTER_ROUND_EN (see fft_out_scaler).
module fft_output_adapter import fft_adapter_pkg::*; #(
  parameter int unsigned OUTPUT_SYMBOL_WIDTH = 16,
  parameter int unsigned EXTRA_LEFT_PADDING  = 4,
  parameter int unsigned EXTRA_RIGHT_PADDING = 2,
  parameter int unsigned FFT_LENGTH          = 1024
) (
  input  logic                                  clock_clk,
  input  logic                                  reset_reset,
  input  logic [2*comp_width(OUTPUT_SYMBOL_WIDTH, EXTRA_LEFT_PADDING,
                             EXTRA_RIGHT_PADDING)-1:0] asi_in_data,
  input  logic                                  asi_in_valid,
  input  logic                                  asi_in_startofpacket,
  input  logic                                  asi_in_endofpacket,
  output logic                                  asi_in_ready,
  output logic [2*OUTPUT_SYMBOL_WIDTH-1:0]      aso_out_data,
  output logic                                  aso_out_valid,
  output logic                                  aso_out_startofpacket,
  output logic                                  aso_out_endofpacket,
  output logic [1:0]                            aso_out_error,
  input  logic                                  aso_out_ready,
  output logic [15:0]                           stat_sat_count
);

  localparam int unsigned S    = OUTPUT_SYMBOL_WIDTH;
  localparam int unsigned CW   = comp_width(S, EXTRA_LEFT_PADDING, EXTRA_RIGHT_PADDING);
  localparam int unsigned DW   = out_data_width(S);
  localparam int unsigned PW   = DW + 4;
  localparam int unsigned CntW = $clog2(FFT_LENGTH + 1) + 1;
  localparam logic [CntW-1:0] FrameLen = CntW'(FFT_LENGTH);

  logic [S-1:0] re_val, im_val;
  logic         re_sat, im_sat, beat_sat;
  logic         accept, load_out, frame_err;
  logic [1:0]   in_err;
  logic [PW-1:0] in_pl;

  logic [PW-1:0]     out_pl_d, out_pl_q, skid_pl_d, skid_pl_q;
  logic              out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
  frame_state_e      state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q, cnt_inc;
  logic [15:0]       sat_cnt_d, sat_cnt_q;

  fft_out_scaler #(
    .OutW    (S),
    .LeftPad (EXTRA_LEFT_PADDING),
    .RightPad(EXTRA_RIGHT_PADDING)
  ) u_scale_re (
    .comp_i (asi_in_data[2*CW-1:CW]),
    .value_o(re_val),
    .sat_o  (re_sat)
  );

  fft_out_scaler #(
    .OutW    (S),
    .LeftPad (EXTRA_LEFT_PADDING),
    .RightPad(EXTRA_RIGHT_PADDING)
  ) u_scale_im (
    .comp_i (asi_in_data[CW-1:0]),
    .value_o(im_val),
    .sat_o  (im_sat)
  );

  assign beat_sat          = re_sat | im_sat;
  assign accept            = asi_in_valid & ~skid_valid_q;
  assign load_out          = ~out_valid_q | aso_out_ready;
  assign in_err[ERR_SAT]   = beat_sat;
  assign in_err[ERR_FRAME] = frame_err;
  assign in_pl = {re_val, im_val, asi_in_startofpacket, asi_in_endofpacket, in_err};

  // Counter saturates above FFT_LENGTH so a runaway packet never re-matches the length.
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_err = 1'b0;
    sat_cnt_d = sat_cnt_q;
    if (accept) begin
      if (asi_in_startofpacket) begin
        state_d   = StInPkt;
        cnt_d     = CntW'(1);
        frame_err = (state_q == StInPkt);
        if (asi_in_endofpacket) begin
          state_d   = StIdle;
          frame_err = 1'b1;
        end
      end else if (state_q == StIdle) begin
        frame_err = 1'b1;
      end else begin
        cnt_d = cnt_inc;
        if (asi_in_endofpacket) begin
          state_d   = StIdle;
          frame_err = (cnt_inc != FrameLen);
        end else begin
          frame_err = (cnt_inc == FrameLen);
        end
      end

      if (asi_in_startofpacket) begin
        sat_cnt_d = {15'd0, beat_sat};
      end else if (beat_sat && sat_cnt_q != 16'hFFFF) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_pl_d     = out_pl_q;
    skid_valid_d = skid_valid_q;
    skid_pl_d    = skid_pl_q;
    if (load_out) begin
      if (skid_valid_q) begin
        // Input is stalled while skid is full, so no new beat competes here.
        out_pl_d     = skid_pl_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_pl_d = in_pl;
      end
    end else if (accept) begin
      skid_pl_d    = in_pl;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      out_valid_q  <= 1'b0;
      out_pl_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_pl_q    <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      sat_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pl_q     <= out_pl_d;
      skid_valid_q <= skid_valid_d;
      skid_pl_q    <= skid_pl_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign asi_in_ready          = ~skid_valid_q;
  assign aso_out_valid         = out_valid_q;
  assign aso_out_data          = out_pl_q[PW-1:4];
  assign aso_out_startofpacket = out_pl_q[3];
  assign aso_out_endofpacket   = out_pl_q[2];
  assign aso_out_error         = out_pl_q[1:0];
  assign stat_sat_count        = sat_cnt_q;

endmodule

// File: tb/tb_fft_output_adapter.sv
// Randomized self-checking bench for fft_output_adapter (S=16, L=4, R=2, FFT_LENGTH=8)
// with directed scaling, saturation, backpressure, framing and reset scenarios.
module tb_fft_output_adapter;

  localparam int unsigned S   = 16;
  localparam int unsigned L   = 4;
  localparam int unsigned R   = 2;
  localparam int unsigned CW  = 22;
  localparam int unsigned LEN = 8;

  logic          clk = 1'b0;
  logic          reset_reset;
  logic [43:0]   asi_in_data;
  logic          asi_in_valid, asi_in_startofpacket, asi_in_endofpacket, asi_in_ready;
  logic [31:0]   aso_out_data;
  logic          aso_out_valid, aso_out_startofpacket, aso_out_endofpacket, aso_out_ready;
  logic [1:0]    aso_out_error;
  logic [15:0]   stat_sat_count;

  always #5 clk = ~clk;

  fft_output_adapter #(
    .OUTPUT_SYMBOL_WIDTH(S),
    .EXTRA_LEFT_PADDING (L),
    .EXTRA_RIGHT_PADDING(R),
    .FFT_LENGTH         (LEN)
  ) dut (
    .clock_clk            (clk),
    .reset_reset          (reset_reset),
    .asi_in_data          (asi_in_data),
    .asi_in_valid         (asi_in_valid),
    .asi_in_startofpacket (asi_in_startofpacket),
    .asi_in_endofpacket   (asi_in_endofpacket),
    .asi_in_ready         (asi_in_ready),
    .aso_out_data         (aso_out_data),
    .aso_out_valid        (aso_out_valid),
    .aso_out_startofpacket(aso_out_startofpacket),
    .aso_out_endofpacket  (aso_out_endofpacket),
    .aso_out_error        (aso_out_error),
    .aso_out_ready        (aso_out_ready),
    .stat_sat_count       (stat_sat_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected beats in order, packet position, saturation statistic.
  logic [35:0] exp_q[$];
  int          pkt_pos = 0;
  int          stat_m  = 0;

  function automatic logic [15:0] ref_scale(input logic [21:0] x, output bit sat);
    longint v;
    v = longint'($signed(x));
`ifdef FFT_OUT_ADAPTER_ROUND_EN
    v = v + (longint'(1) << (R - 1));
`endif
    v   = v >>> R;
    sat = 1'b0;
    if (v > 32767) begin
      sat = 1'b1;
      v   = 32767;
    end else if (v < -32768) begin
      sat = 1'b1;
      v   = -32768;
    end
    return v[15:0];
  endfunction

  task automatic model_accept(input logic [21:0] re, input logic [21:0] im, input bit sop,
                              input bit eop);
    bit          sr, si, sat, ferr;
    logic [15:0] vr, vi;
    vr  = ref_scale(re, sr);
    vi  = ref_scale(im, si);
    sat = sr | si;
    ferr = 1'b0;
    if (sop) begin
      ferr    = (pkt_pos != 0) || eop;
      pkt_pos = eop ? 0 : 1;
    end else if (pkt_pos == 0) begin
      ferr = 1'b1;
    end else begin
      pkt_pos++;
      if (eop) begin
        ferr    = (pkt_pos != LEN);
        pkt_pos = 0;
      end else begin
        ferr = (pkt_pos == LEN);
      end
    end
    if (sop) stat_m = sat ? 1 : 0;
    else if (sat && stat_m < 65535) stat_m++;
    exp_q.push_back({vr, vi, sop, eop, ferr, sat});
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cycle(input bit v, input bit sop, input bit eop, input logic [21:0] re,
                       input logic [21:0] im, input bit ordy, output bit acc);
    logic [35:0] got, snap, exp;
    bit          stall;
    asi_in_valid         = v;
    asi_in_startofpacket = sop;
    asi_in_endofpacket   = eop;
    asi_in_data          = {re, im};
    aso_out_ready        = ordy;
    acc  = v && asi_in_ready;
    got  = {aso_out_data, aso_out_startofpacket, aso_out_endofpacket, aso_out_error};
    snap = got;
    if (aso_out_valid && ordy) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
      check_eq("out_beat", got, exp);
    end
    stall = aso_out_valid && !ordy;
    if (acc) model_accept(re, im, sop, eop);
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_count", stat_sat_count, stat_m);
    if (stall) begin
      got = {aso_out_data, aso_out_startofpacket, aso_out_endofpacket, aso_out_error};
      check_eq("stall_hold", {aso_out_valid, got}, {1'b1, snap});
    end
  endtask

  task automatic do_reset(input bit v);
    reset_reset   = 1'b1;
    asi_in_valid  = v;
    aso_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_reset = 1'b0;
    exp_q.delete();
    pkt_pos = 0;
    stat_m  = 0;
    check_eq("rst_valid", aso_out_valid, 0);
    check_eq("rst_ready", asi_in_ready, 1);
    check_eq("rst_stat", stat_sat_count, 0);
    check_eq("rst_data", {aso_out_data, aso_out_startofpacket, aso_out_endofpacket,
                          aso_out_error}, 0);
  endtask

  logic [21:0] sm_re, sm_im;

  function automatic logic [21:0] small_val();
    return 22'(int'($urandom_range(0, 262143)) - 131072);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx, gp, cyc;
    bit v, sop, eop, ordy;
    logic [21:0] re, im;

    reset_reset          = 1'b1;
    asi_in_valid         = 1'b0;
    asi_in_startofpacket = 1'b0;
    asi_in_endofpacket   = 1'b0;
    asi_in_data          = '0;
    aso_out_ready        = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Scaling: sop beat, visible the cycle after acceptance.
    cycle(1, 1, 0, 22'd6, 22'd5, 1, acc);
    check_eq("scale_acc", acc, 1);
    check_eq("scale_valid", aso_out_valid, 1);
`ifdef FFT_OUT_ADAPTER_ROUND_EN
    check_eq("scale_data", aso_out_data, 32'h0002_0001);
`else
    check_eq("scale_data", aso_out_data, 32'h0001_0001);
`endif
    check_eq("scale_sat", aso_out_error[0], 0);

    // Saturation: +2^19 and -2^19 in the same packet.
    cycle(1, 0, 0, 22'h080000, 22'h380000, 1, acc);
    check_eq("sat_data", aso_out_data, 32'h7FFF_8000);
    check_eq("sat_flag", aso_out_error[0], 1);
    check_eq("sat_stat", stat_sat_count, 1);
    for (int k = 3; k <= LEN; k++) cycle(1, 0, k == LEN, 22'(k), 22'(k), 1, acc);
    check_eq("pkt1_eop_err", aso_out_error[1], 0);

    // Backpressure: continuous valid, downstream stalls for 5 cycles after beat 1.
    idx = 0;
    for (cyc = 0; cyc < 40 && idx < LEN; cyc++) begin
      ordy = !(cyc >= 2 && cyc < 7);
      cycle(1, idx == 0, idx == LEN - 1, 22'(idx << R), 22'd0, ordy, acc);
      if (acc) idx++;
      if (cyc == 2) check_eq("bp_ready_drop", asi_in_ready, 0);
      if (cyc >= 7 && cyc <= 12) check_eq("bp_no_gap", aso_out_valid, 1);
    end
    check_eq("bp_all_sent", idx, LEN);

    // Framing: early eop at beat 6, two stray beats in idle, then a clean packet.
    for (int k = 1; k <= 6; k++) cycle(1, k == 1, k == 6, 22'(k), -22'(k), 1, acc);
    check_eq("frame_early_eop", aso_out_error[1], 1);
    cycle(1, 0, 0, 22'd9, 22'd9, 1, acc);
    check_eq("frame_idle_beat", aso_out_error[1], 1);
    cycle(1, 0, 0, 22'd9, 22'd9, 1, acc);
    for (int k = 1; k <= LEN; k++) begin
      cycle(1, k == 1, k == LEN, 22'(k), 22'(k), 1, acc);
      if (k == 1) check_eq("frame_clean_sop", aso_out_error[1], 0);
    end
    check_eq("frame_clean_eop", aso_out_error[1], 0);
    cycle(0, 0, 0, 22'd0, 22'd0, 1, acc);

    // Reset mid-packet with the skid register full.
    for (int k = 0; k < 3; k++) cycle(1, k == 0, 0, 22'h0F0000, 22'd1, 1, acc);
    cycle(1, 0, 0, 22'h0F0000, 22'd1, 0, acc);
    check_eq("mid_skid_full", asi_in_ready, 0);
    check_eq("mid_stat_nz", stat_sat_count, 4);
    do_reset(1'b1);
    for (int k = 1; k <= LEN; k++) cycle(1, k == 1, k == LEN, 22'(k * 4), 22'(k), 1, acc);
    check_eq("post_rst_err", aso_out_error, 0);
    check_eq("post_rst_stat", stat_sat_count, 0);

    // Random traffic: mostly well-formed packets, occasional framing faults and stalls.
    gp = 0;
    for (int c = 0; c < 600; c++) begin
      v    = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      sop  = (gp == 0);
      eop  = (gp == LEN - 1);
      if ($urandom_range(0, 19) == 0) sop = !sop;
      if ($urandom_range(0, 19) == 0) eop = !eop;
      sm_re = small_val();
      sm_im = small_val();
      re = $urandom_range(0, 1) ? sm_re : 22'($urandom);
      im = $urandom_range(0, 1) ? sm_im : 22'($urandom);
      cycle(v, sop, eop, re, im, ordy, acc);
      if (acc) gp = (gp + 1) % LEN;
    end

    for (int c = 0; c < 20 && (exp_q.size() > 0 || aso_out_valid); c++) begin
      cycle(0, 0, 0, 22'd0, 22'd0, 1, acc);
    end
    check_eq("drain_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_output_adapter.md
Name: fft_output_adapter

Overview:
- Receive-side counterpart of the FFT input adapter.
- Takes padded complex samples from the FFT core's Avalon-ST source and narrows each real/imag component back to OUTPUT_SYMBOL_WIDTH:
  - drops the EXTRA_RIGHT_PADDING fraction LSBs;
  - saturates the EXTRA_LEFT_PADDING growth MSBs.
- Registers data through a 2-entry skid buffer and checks packet framing against FFT_LENGTH.
- Sits between the FFT core output and downstream Avalon-ST consumers.

Parameters:
- OUTPUT_SYMBOL_WIDTH, 16: width of each output component.
- EXTRA_LEFT_PADDING, 4: guard MSBs per input component (L).
- EXTRA_RIGHT_PADDING, 2: fraction LSBs per input component (R). 0 is legal: no rounding, pure saturation.
- FFT_LENGTH, 1024: expected beats per packet. Must be ≥2.

Ports:
- clock_clk  in  1  clock
- reset_reset  in  1  synchronous, active-high reset
- asi_in_data  in  2*CW  {real, imag}, each two's complement, where CW = L+OUTPUT_SYMBOL_WIDTH+R
- asi_in_valid  in  1  input valid
- asi_in_startofpacket  in  1  input start of packet
- asi_in_endofpacket  in  1  input end of packet
- asi_in_ready  out  1  registered ready
- aso_out_data  out  2*OUTPUT_SYMBOL_WIDTH  {real, imag}
- aso_out_valid  out  1  output valid
- aso_out_startofpacket  out  1  output start of packet
- aso_out_endofpacket  out  1  output end of packet
- aso_out_error  out  2  per-beat flags: [0] saturation occurred on this beat, [1] framing error on this beat
- aso_out_ready  in  1  downstream ready
- stat_sat_count  out  16  saturation beats in current/last packet; saturates at 0xFFFF

Behaviour:
- Clock and reset: one clock, clock_clk. Reset is synchronous, active-high on reset_reset.
- Reset values:
  - aso_out_valid, sop, eop, error = 0; aso_out_data = 0;
  - asi_in_ready = 1; stat_sat_count = 0;
  - framing FSM = IDLE, beat counter = 0.
- Reset mid-packet: both buffer entries discarded. The next cycle shows aso_out_valid = 0. No partial-packet recovery.
- Acceptance: an input beat is accepted when asi_in_valid && asi_in_ready.
- Per component (real and imag, identical):
  - x >> R (arithmetic); with the round feature, add 2^(R-1) first, computed in CW+1 bits.
  - If the result does not fit OUTPUT_SYMBOL_WIDTH signed, clamp to +max (0x7FFF) or min (0x8000).
  - error[0] = real saturated OR imag saturated.
- Latency: accepted beat appears on aso_out_* the next cycle when the output stage is empty or draining.
- Skid buffer:
  - Output register plus one skid register.
  - asi_in_ready = !skid_valid (registered).
  - If the output stage holds data, aso_out_ready = 0 and an input beat is accepted, the beat goes to skid and ready drops the next cycle.
  - Skid moves to output when the output fires.
  - Throughput 1 beat/cycle with aso_out_ready = 1.
  - No loss, duplication or reordering.
  - aso_out_* held stable while aso_out_valid && !aso_out_ready.
- Framing FSM (on accepted beats): states IDLE, IN_PKT. cnt = beats accepted in the current packet.
  - IDLE, sop=1: go to IN_PKT, cnt=1.
    - If eop=1 on the same beat: error[1]=1, stay IDLE.
  - IDLE, sop=0: beat forwarded, error[1]=1.
  - IN_PKT, sop=1: error[1]=1, restart cnt=1 (treated as new packet).
  - IN_PKT, eop=1: go to IDLE. error[1]=1 unless cnt+1 == FFT_LENGTH.
  - IN_PKT, cnt+1 == FFT_LENGTH without eop: error[1]=1, continue counting.
  - sop/eop are forwarded unchanged.
  - error flags travel with their beat through the skid buffer.
- stat_sat_count:
  - Cleared to 0 then incremented on an accepted sop beat that saturated (i.e. loaded with error[0]).
  - Otherwise +1 per accepted saturating beat; sticks at 0xFFFF.

Optional Feature:
- Macro: FFT_OUT_ADAPTER_ROUND_EN.
- Defined: round-half-up (+2^(R-1) before shift) when R>0. Saturation is checked after rounding, so rounding into overflow clamps.
- Undefined: plain truncation (floor). Fewer adders.
- R=0: both builds are identical.

Decomposition:
- Package fft_adapter_pkg:
  - width functions (component width CW, output data width);
  - error-bit index constants ERR_SAT=0, ERR_FRAME=1;
  - framing state enum IDLE/IN_PKT.
- One sub-module fft_out_scaler: per-component round + saturate, combinational, outputs value and sat flag. Instantiated twice (real, imag).
- Skid buffer and FSM stay in the top module.

Test Plan (defaults: S=16, L=4, R=2, CW=22; FFT_LENGTH overridden to 8):
- Scaling: real=6, imag=5 → ROUND_EN: real=2, imag=1; without: real=1, imag=1. error[0]=0, output one cycle after acceptance.
- Saturation: real=0x080000 (+2^19), imag=0x380000 (−2^19) → real=0x7FFF, imag=0x8000, error[0]=1, stat_sat_count increments by 1.
- Backpressure: continuous valid input 0,1,2…; aso_out_ready low for 5 cycles after beat 1 → asi_in_ready low the cycle after beat 2 is skidded. Output sequence 0,1,2,3… with no gap, duplicate or loss once ready returns.
- Framing: 8-beat packet with eop on beat 6 → error[1]=1 on beat 6 only; next sop starts a clean packet with error[1]=0. Beat without sop in IDLE → error[1]=1.
- Reset mid-packet: assert reset_reset for 1 cycle at beat 4 with skid full → next cycle aso_out_valid=0, asi_in_ready=1, stat_sat_count=0. A fresh 8-beat packet then passes with no errors.
